// File: rtl/accelerator_core_data_feeder.sv
// accelerator_core_data_feeder
// Buffers input activations (data) and weights for the accelerator core in two
// independent FIFOs and answers single-word requests from the core.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   s_data/_val/_rdy         data word write port from the load path
//   s_weight/_val/_rdy       weight word write port from the load path
//   o_data_req, o_weight_req core request pulses, one word per pulse
//   i_data/_val              data word to core, valid for one cycle per word
//   i_weight/_val            weight word to core, valid for one cycle per word
//   clear_cnt                synchronous clear of both stall counters
//   data_stall_cnt           cycles a data request waited on an empty FIFO
//   weight_stall_cnt         cycles a weight request waited on an empty FIFO
//   req_ovf                  sticky flag: a request was dropped on counter saturation
module accelerator_core_data_feeder #(
    parameter int unsigned BIT_WIDTH     = 8,
    parameter int unsigned NUM_CHANNEL   = 3,
    parameter int unsigned NUM_KERNEL    = 4,
    parameter int unsigned REG_WIDTH     = 32,
    parameter int unsigned DATA_DEPTH    = 16,
    parameter int unsigned WEIGHT_DEPTH  = 8,
    parameter int unsigned REQ_CNT_WIDTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]            s_data,
    input  logic                                      s_data_val,
    output logic                                      s_data_rdy,
    input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] s_weight,
    input  logic                                      s_weight_val,
    output logic                                      s_weight_rdy,
    input  logic                                      o_data_req,
    output logic [BIT_WIDTH*NUM_CHANNEL-1:0]            i_data,
    output logic                                      i_data_val,
    input  logic                                      o_weight_req,
    output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
    output logic                                      i_weight_val,
    input  logic                                      clear_cnt,
    output logic [REG_WIDTH-1:0]                      data_stall_cnt,
    output logic [REG_WIDTH-1:0]                      weight_stall_cnt,
    output logic                                      req_ovf
);

    localparam int unsigned DW  = BIT_WIDTH * NUM_CHANNEL;
    localparam int unsigned WW  = DW * NUM_KERNEL;
    localparam int unsigned DAW = $clog2(DATA_DEPTH);
    localparam int unsigned WAW = $clog2(WEIGHT_DEPTH);
    localparam int unsigned RCW = REQ_CNT_WIDTH;

    localparam logic [DAW:0]   DATA_FULL   = (DAW + 1)'(DATA_DEPTH);
    localparam logic [WAW:0]   WEIGHT_FULL = (WAW + 1)'(WEIGHT_DEPTH);
    localparam logic [RCW-1:0] PEND_MAX    = {RCW{1'b1}};

    // ---------------- data channel ----------------
    logic [DW-1:0]  data_mem [DATA_DEPTH];
    logic [DAW-1:0] data_wptr_q, data_rptr_q;
    logic [DAW:0]   data_cnt_q, data_cnt_d;
    logic [RCW-1:0] data_pend_q, data_pend_d;
    logic           data_wr, data_want, data_pop, data_drop;

    assign s_data_rdy = rst && (data_cnt_q != DATA_FULL);
    assign data_wr    = s_data_val && s_data_rdy;
    assign data_want  = o_data_req || (data_pend_q != '0);
    assign data_pop   = data_want && (data_cnt_q != '0);
    // A new request with no pop cannot be recorded once pend is saturated.
    assign data_drop  = o_data_req && !data_pop && (data_pend_q == PEND_MAX);

    always_comb begin
        data_pend_d = data_pend_q;
        if (o_data_req && !data_pop && !data_drop) begin
            data_pend_d = data_pend_q + RCW'(1);
        end else if (!o_data_req && data_pop) begin
            data_pend_d = data_pend_q - RCW'(1);
        end
        data_cnt_d = data_cnt_q;
        if (data_wr && !data_pop) begin
            data_cnt_d = data_cnt_q + (DAW + 1)'(1);
        end else if (!data_wr && data_pop) begin
            data_cnt_d = data_cnt_q - (DAW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (data_wr) begin
            data_mem[data_wptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_wptr_q    <= '0;
            data_rptr_q    <= '0;
            data_cnt_q     <= '0;
            data_pend_q    <= '0;
            i_data         <= '0;
            i_data_val     <= 1'b0;
            data_stall_cnt <= '0;
        end else begin
            if (data_wr) begin
                data_wptr_q <= data_wptr_q + DAW'(1);
            end
            if (data_pop) begin
                data_rptr_q <= data_rptr_q + DAW'(1);
                i_data      <= data_mem[data_rptr_q];
            end
            data_cnt_q  <= data_cnt_d;
            data_pend_q <= data_pend_d;
            i_data_val  <= data_pop;
            if (clear_cnt) begin
                data_stall_cnt <= '0;
            end else if (data_want && (data_cnt_q == '0)) begin
                data_stall_cnt <= data_stall_cnt + REG_WIDTH'(1);
            end
        end
    end

    // ---------------- weight channel ----------------
    logic [WW-1:0]  weight_mem [WEIGHT_DEPTH];
    logic [WAW-1:0] weight_wptr_q, weight_rptr_q;
    logic [WAW:0]   weight_cnt_q, weight_cnt_d;
    logic [RCW-1:0] weight_pend_q, weight_pend_d;
    logic           weight_wr, weight_want, weight_pop, weight_drop;

    assign s_weight_rdy = rst && (weight_cnt_q != WEIGHT_FULL);
    assign weight_wr    = s_weight_val && s_weight_rdy;
    assign weight_want  = o_weight_req || (weight_pend_q != '0);
    assign weight_pop   = weight_want && (weight_cnt_q != '0);
    assign weight_drop  = o_weight_req && !weight_pop && (weight_pend_q == PEND_MAX);

    always_comb begin
        weight_pend_d = weight_pend_q;
        if (o_weight_req && !weight_pop && !weight_drop) begin
            weight_pend_d = weight_pend_q + RCW'(1);
        end else if (!o_weight_req && weight_pop) begin
            weight_pend_d = weight_pend_q - RCW'(1);
        end
        weight_cnt_d = weight_cnt_q;
        if (weight_wr && !weight_pop) begin
            weight_cnt_d = weight_cnt_q + (WAW + 1)'(1);
        end else if (!weight_wr && weight_pop) begin
            weight_cnt_d = weight_cnt_q - (WAW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (weight_wr) begin
            weight_mem[weight_wptr_q] <= s_weight;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_wptr_q    <= '0;
            weight_rptr_q    <= '0;
            weight_cnt_q     <= '0;
            weight_pend_q    <= '0;
            i_weight         <= '0;
            i_weight_val     <= 1'b0;
            weight_stall_cnt <= '0;
        end else begin
            if (weight_wr) begin
                weight_wptr_q <= weight_wptr_q + WAW'(1);
            end
            if (weight_pop) begin
                weight_rptr_q <= weight_rptr_q + WAW'(1);
                i_weight      <= weight_mem[weight_rptr_q];
            end
            weight_cnt_q  <= weight_cnt_d;
            weight_pend_q <= weight_pend_d;
            i_weight_val  <= weight_pop;
            if (clear_cnt) begin
                weight_stall_cnt <= '0;
            end else if (weight_want && (weight_cnt_q == '0)) begin
                weight_stall_cnt <= weight_stall_cnt + REG_WIDTH'(1);
            end
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ovf <= 1'b0;
        end else if (data_drop || weight_drop) begin
            req_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_accelerator_core_data_feeder.sv
// Directed testbench for accelerator_core_data_feeder. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point, so each step()
// observes the result of exactly one clock edge.
module tb_accelerator_core_data_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_data;
    logic        s_data_val;
    logic        s_data_rdy;
    logic [95:0] s_weight;
    logic        s_weight_val;
    logic        s_weight_rdy;
    logic        o_data_req;
    logic [23:0] i_data;
    logic        i_data_val;
    logic        o_weight_req;
    logic [95:0] i_weight;
    logic        i_weight_val;
    logic        clear_cnt;
    logic [31:0] data_stall_cnt;
    logic [31:0] weight_stall_cnt;
    logic        req_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    accelerator_core_data_feeder dut (
        .clk              (clk),
        .rst              (rst),
        .s_data           (s_data),
        .s_data_val       (s_data_val),
        .s_data_rdy       (s_data_rdy),
        .s_weight         (s_weight),
        .s_weight_val     (s_weight_val),
        .s_weight_rdy     (s_weight_rdy),
        .o_data_req       (o_data_req),
        .i_data           (i_data),
        .i_data_val       (i_data_val),
        .o_weight_req     (o_weight_req),
        .i_weight         (i_weight),
        .i_weight_val     (i_weight_val),
        .clear_cnt        (clear_cnt),
        .data_stall_cnt   (data_stall_cnt),
        .weight_stall_cnt (weight_stall_cnt),
        .req_ovf          (req_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_data       = '0;
        s_data_val   = 1'b0;
        s_weight     = '0;
        s_weight_val = 1'b0;
        o_data_req   = 1'b0;
        o_weight_req = 1'b0;
        clear_cnt    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        #3;
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        total_cnt++;
        if (s_data_rdy !== 1'b0 || s_weight_rdy !== 1'b0) begin
            $display("FAIL reset_rdy: data_rdy=%b weight_rdy=%b, required 0/0", s_data_rdy,
                     s_weight_rdy);
        end else pass_cnt++;
        total_cnt++;
        if (i_data_val !== 1'b0 || i_weight_val !== 1'b0 || i_data !== 24'h0 ||
            i_weight !== 96'h0 || data_stall_cnt !== 32'h0 || weight_stall_cnt !== 32'h0 ||
            req_ovf !== 1'b0) begin
            $display("FAIL reset_outputs: dval=%b wval=%b data=%h weight=%h dstall=%0d wstall=%0d ovf=%b, required all 0",
                     i_data_val, i_weight_val, i_data, i_weight, data_stall_cnt,
                     weight_stall_cnt, req_ovf);
        end else pass_cnt++;
        #3;
        rst = 1'b1;
        step();
        total_cnt++;
        if (s_data_rdy !== 1'b1 || s_weight_rdy !== 1'b1) begin
            $display("FAIL reset_release_rdy: data_rdy=%b weight_rdy=%b, required 1/1",
                     s_data_rdy, s_weight_rdy);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_data     = 24'h201000 + 24'(i);
            s_data_val = 1'b1;
            step();
        end
        s_data_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            o_data_req = 1'b1;
            step();
            total_cnt++;
            if (i_data_val !== 1'b1 || i_data !== 24'h201000 + 24'(i)) begin
                $display("FAIL basic_pop%0d: val=%b data=%h, required val=1 data=%h", i,
                         i_data_val, i_data, 24'h201000 + 24'(i));
            end else pass_cnt++;
        end
        o_data_req = 1'b0;
        step();
        total_cnt++;
        if (i_data_val !== 1'b0 || i_data !== 24'h201003) begin
            $display("FAIL basic_idle: val=%b data=%h, required val=0 data=201003", i_data_val,
                     i_data);
        end else pass_cnt++;
        total_cnt++;
        if (data_stall_cnt !== 32'd0) begin
            $display("FAIL basic_stall: got %0d, required 0", data_stall_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_starved();
        int nval;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            o_data_req = 1'b1;
            step();
        end
        o_data_req = 1'b0;
        nval = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i_data_val) nval++;
        end
        total_cnt++;
        if (nval != 0) begin
            $display("FAIL starved_no_early_val: got %0d valids, required 0", nval);
        end else pass_cnt++;
        // Writes at edges N, N+1, N+2; valids after N+1, N+2, N+3.
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                s_data     = 24'hAB0000 + 24'(i);
                s_data_val = 1'b1;
            end else begin
                s_data_val = 1'b0;
            end
            step();
            if (i == 0) begin
                total_cnt++;
                if (i_data_val !== 1'b0) begin
                    $display("FAIL starved_write_latency: val=%b after write edge, required 0",
                             i_data_val);
                end else pass_cnt++;
            end else if (i <= 3) begin
                total_cnt++;
                if (i_data_val !== 1'b1 || i_data !== 24'hAB0000 + 24'(i - 1)) begin
                    $display("FAIL starved_pop%0d: val=%b data=%h, required val=1 data=%h",
                             i - 1, i_data_val, i_data, 24'hAB0000 + 24'(i - 1));
                end else pass_cnt++;
            end else begin
                total_cnt++;
                if (i_data_val !== 1'b0) begin
                    $display("FAIL starved_drained: val=%b, required 0", i_data_val);
                end else pass_cnt++;
            end
        end
        total_cnt++;
        if (data_stall_cnt !== 32'd9) begin
            $display("FAIL starved_stall: got %0d, required 9", data_stall_cnt);
        end else pass_cnt++;
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        total_cnt++;
        if (data_stall_cnt !== 32'd0) begin
            $display("FAIL clear_cnt: got %0d, required 0", data_stall_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_full();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            s_data     = 24'h300000 + 24'(i);
            s_data_val = 1'b1;
            step();
            if (i < 15 && s_data_rdy !== 1'b1) bad++;
        end
        total_cnt++;
        if (bad != 0) begin
            $display("FAIL full_rdy_early: rdy dropped %0d times before 16th write, required 0",
                     bad);
        end else pass_cnt++;
        total_cnt++;
        if (s_data_rdy !== 1'b0) begin
            $display("FAIL full_rdy: got %b after 16 writes, required 0", s_data_rdy);
        end else pass_cnt++;
        s_data = 24'hBADBAD;
        step();
        s_data_val = 1'b0;
        o_data_req = 1'b1;
        step();
        total_cnt++;
        if (i_data_val !== 1'b1 || i_data !== 24'h300000) begin
            $display("FAIL full_pop0: val=%b data=%h, required val=1 data=300000", i_data_val,
                     i_data);
        end else pass_cnt++;
        total_cnt++;
        if (s_data_rdy !== 1'b1) begin
            $display("FAIL full_rdy_return: got %b after pop, required 1", s_data_rdy);
        end else pass_cnt++;
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            step();
            if (i_data_val !== 1'b1 || i_data !== 24'h300000 + 24'(i)) bad++;
        end
        total_cnt++;
        if (bad != 0) begin
            $display("FAIL full_drain: %0d wrong pops of words 1..15, required 0", bad);
        end else pass_cnt++;
        // The ignored 17th word must not appear.
        step();
        o_data_req = 1'b0;
        total_cnt++;
        if (i_data_val !== 1'b0) begin
            $display("FAIL full_17th_ignored: val=%b data=%h, required val=0", i_data_val,
                     i_data);
        end else pass_cnt++;
    endtask

    task automatic test_saturation();
        int nval;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            o_data_req = 1'b1;
            step();
        end
        total_cnt++;
        if (req_ovf !== 1'b0) begin
            $display("FAIL sat_no_ovf_at15: ovf=%b, required 0", req_ovf);
        end else pass_cnt++;
        step();
        o_data_req = 1'b0;
        total_cnt++;
        if (req_ovf !== 1'b1) begin
            $display("FAIL sat_ovf: ovf=%b after 16 requests, required 1", req_ovf);
        end else pass_cnt++;
        nval = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 16) begin
                s_data     = 24'h500000 + 24'(i);
                s_data_val = 1'b1;
            end else begin
                s_data_val = 1'b0;
            end
            step();
            if (i_data_val) nval++;
        end
        total_cnt++;
        if (nval != 15) begin
            $display("FAIL sat_valids: got %0d valids, required 15", nval);
        end else pass_cnt++;
        total_cnt++;
        if (req_ovf !== 1'b1 || i_data !== 24'h50000E) begin
            $display("FAIL sat_sticky: ovf=%b last=%h, required ovf=1 last=50000e", req_ovf,
                     i_data);
        end else pass_cnt++;
    endtask

    task automatic test_weight_independence();
        int nval;
        int bad_order;
        int data_noise;
        do_reset();
        nval       = 0;
        bad_order  = 0;
        data_noise = 0;
        // Write and request one weight per cycle for 4 cycles, then idle to drain.
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                s_weight     = 96'(i);
                s_weight_val = 1'b1;
                o_weight_req = 1'b1;
            end else begin
                s_weight_val = 1'b0;
                o_weight_req = 1'b0;
            end
            step();
            if (i_weight_val) begin
                if (i_weight !== 96'(nval)) bad_order++;
                nval++;
            end
            if (i_data_val !== 1'b0 || i_data !== 24'h0) data_noise++;
        end
        total_cnt++;
        if (nval != 4 || bad_order != 0) begin
            $display("FAIL weight_order: %0d valids with %0d out of order, required 4 and 0",
                     nval, bad_order);
        end else pass_cnt++;
        total_cnt++;
        if (data_noise != 0 || data_stall_cnt !== 32'd0) begin
            $display("FAIL weight_isolation: data active %0d cycles, dstall=%0d, required 0/0",
                     data_noise, data_stall_cnt);
        end else pass_cnt++;
        total_cnt++;
        if (weight_stall_cnt !== 32'd1) begin
            $display("FAIL weight_stall: got %0d, required 1", weight_stall_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_data       = 24'h600000 + 24'(i);
            s_data_val   = 1'b1;
            s_weight     = 96'h70 + 96'(i);
            s_weight_val = 1'b1;
            step();
        end
        s_data_val   = 1'b0;
        s_weight_val = 1'b0;
        o_data_req   = 1'b1;
        o_weight_req = 1'b1;
        step();
        total_cnt++;
        if (i_data_val !== 1'b1 || i_weight_val !== 1'b1) begin
            $display("FAIL midrst_pre: dval=%b wval=%b, required 1/1", i_data_val, i_weight_val);
        end else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (i_data_val !== 1'b0 || i_weight_val !== 1'b0 || s_data_rdy !== 1'b0 ||
            s_weight_rdy !== 1'b0 || i_data !== 24'h0 || i_weight !== 96'h0) begin
            $display("FAIL midrst_drop: dval=%b wval=%b drdy=%b wrdy=%b data=%h, required all 0",
                     i_data_val, i_weight_val, s_data_rdy, s_weight_rdy, i_data);
        end else pass_cnt++;
        o_data_req   = 1'b0;
        o_weight_req = 1'b0;
        #1;
        rst = 1'b1;
        step();
        o_data_req = 1'b1;
        step();
        o_data_req = 1'b0;
        step();
        step();
        total_cnt++;
        if (i_data_val !== 1'b0 || s_data_rdy !== 1'b1) begin
            $display("FAIL midrst_flushed: val=%b rdy=%b, required val=0 rdy=1", i_data_val,
                     s_data_rdy);
        end else pass_cnt++;
        s_data     = 24'h777777;
        s_data_val = 1'b1;
        step();
        s_data_val = 1'b0;
        step();
        total_cnt++;
        if (i_data_val !== 1'b1 || i_data !== 24'h777777) begin
            $display("FAIL midrst_new_word: val=%b data=%h, required val=1 data=777777",
                     i_data_val, i_data);
        end else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_starved();
        test_full();
        test_saturation();
        test_weight_independence();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
